dct_block_sequencer: RTL and testbench

- Front-end controller for the serial 16-point DA-DCT engine.
- Accepts a valid/ready sample stream into a ping-pong buffer of two 16-sample banks.
- For each full bank: restarts the engine, streams the 16 samples into it, captures its 4 coefficient results and forwards them on a valid/ready output stream.
- Sits between the sample source and the engine; it is the only driver of the engine's reset and sample input.

---
 rtl/dct_block_sequencer_pkg.sv | 16 +
 rtl/dct_block_sequencer_if.sv | 29 ++
 rtl/dct_block_sequencer_fifo.sv | 40 ++++
 rtl/dct_block_sequencer.sv | 168 ++++++++++++++++
 tb/tb_dct_block_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_block_sequencer_pkg.sv
// Shared types and constants for the DA-DCT front-end sequencer.
package dct_seq_pkg;

  localparam int BLK_LEN  = 16;
  localparam int NCOEF    = 4;
  localparam int SAMPLE_W = 15;
  localparam int COEF_W   = 18;

  typedef enum logic [1:0] {IDLE, ERST, LOAD, WAIT} seq_state_t;

  typedef struct packed {
    logic [1:0]        idx;
    logic [COEF_W-1:0] data;
  } coef_entry_t;

endpackage

// File: rtl/dct_block_sequencer_if.sv
// Sample stream, coefficient stream and engine connection of the sequencer.
// The sequencer takes the master view (it masters the coefficient stream and
// the engine); the surrounding logic takes the slave view.
interface dct_block_sequencer_if;
  import dct_seq_pkg::*;

  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_data;
  logic                m_valid;
  logic                m_ready;
  logic [COEF_W-1:0]   m_data;
  logic [1:0]          m_idx;
  logic                m_last;
  logic                eng_rst;
  logic [SAMPLE_W-1:0] eng_in;
  logic [COEF_W-1:0]   eng_out;
  logic                eng_done;

  modport master (
    input  s_valid, s_data, m_ready, eng_out, eng_done,
    output s_ready, m_valid, m_data, m_idx, m_last, eng_rst, eng_in
  );

  modport slave (
    output s_valid, s_data, m_ready, eng_out, eng_done,
    input  s_ready, m_valid, m_data, m_idx, m_last, eng_rst, eng_in
  );
endinterface

// File: rtl/dct_block_sequencer_fifo.sv
// 4-deep synchronous FIFO holding {idx, data} coefficient entries.
module dct_coef_fifo
  import dct_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  coef_entry_t din,
  output coef_entry_t dout,
  output logic [2:0]  count
);
  coef_entry_t mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_pop  = pop && (count != 3'd0);
  assign do_push = push && ((count != 3'd4) || do_pop);
  assign dout    = mem[rd_ptr];

  // pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

  // entry storage; contents need no reset because count gates validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/dct_block_sequencer.sv
// Front-end sequencer for the serial 16-point DA-DCT engine: ping-pong sample
// banks on the input, engine restart/load/collect FSM, coefficient FIFO out.
//
//   state | meaning
//   IDLE  | engine held in reset, waiting for a full bank and an empty FIFO
//   ERST  | one-cycle engine restart, sample counter cleared
//   LOAD  | stream 16 samples of the drain bank into the engine
//   WAIT  | collect 4 done pulses into the FIFO, abort on timeout
module dct_block_sequencer #(
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  dct_block_sequencer_if.master bus,
  output logic                  err_timeout,
  output logic [15:0]           blk_count
);
  import dct_seq_pkg::*;

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [SAMPLE_W-1:0] bank [2][BLK_LEN];
  logic [1:0]          full;
  logic                fill_bank;
  logic                drain_bank;
  logic [3:0]          wr_cnt;
  logic                s_accept;

  seq_state_t          state;
  seq_state_t          state_nx;
  logic [3:0]          cnt;
  logic [1:0]          coef_cnt;
  logic [TW-1:0]       timer;
  logic                push;
  logic                blk_done;
  logic                abort;
  logic                release_bank;

  coef_entry_t         fifo_din;
  coef_entry_t         fifo_head;
  logic [2:0]          fifo_cnt;
  logic                pop;

  assign bus.s_ready  = !full[fill_bank];
  assign s_accept     = bus.s_valid && bus.s_ready;
  assign release_bank = blk_done || abort;

  // sample bank writes
  always_ff @(posedge clk) begin
    if (s_accept) bank[fill_bank][wr_cnt] <= bus.s_data;
  end

  // bank full flags and fill/drain pointers; fill and drain never name the
  // same bank when both update, so set and clear can coexist
  always_ff @(posedge clk) begin
    if (rst) begin
      full       <= '0;
      fill_bank  <= 1'b0;
      drain_bank <= 1'b0;
      wr_cnt     <= '0;
    end else begin
      if (release_bank) begin
        full[drain_bank] <= 1'b0;
        drain_bank       <= !drain_bank;
      end
      if (s_accept) begin
        wr_cnt <= wr_cnt + 4'd1;
        if (wr_cnt == 4'(BLK_LEN - 1)) begin
          full[fill_bank] <= 1'b1;
          fill_bank       <= !fill_bank;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state, engine drive and FIFO push decode
  always_comb begin
    state_nx    = state;
    bus.eng_rst = 1'b1;
    bus.eng_in  = '0;
    push        = 1'b0;
    blk_done    = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: if (full[drain_bank] && fifo_cnt == 3'd0) state_nx = ERST;
      ERST: state_nx = LOAD;
      LOAD: begin
        bus.eng_rst = 1'b0;
        bus.eng_in  = bank[drain_bank][cnt];
        if (cnt == 4'(BLK_LEN - 1)) state_nx = WAIT;
      end
      WAIT: begin
        bus.eng_rst = 1'b0;
        push        = bus.eng_done;
        if (bus.eng_done && coef_cnt == 2'(NCOEF - 1)) begin
          blk_done = 1'b1;
          // restart directly only when the previous three coefficients have
          // already left, so just this block's last entry remains queued
          state_nx = (full[!drain_bank] && fifo_cnt == 3'd0) ? ERST : IDLE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // sample, coefficient and timeout counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      coef_cnt <= '0;
      timer    <= '0;
    end else begin
      case (state)
        ERST: cnt <= '0;
        LOAD: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(BLK_LEN - 1)) begin
            coef_cnt <= '0;
            timer    <= '0;
          end
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (push) coef_cnt <= coef_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // sticky abort flag and completed-block counter
  always_ff @(posedge clk) begin
    if (rst) begin
      err_timeout <= 1'b0;
      blk_count   <= '0;
    end else begin
      if (abort)    err_timeout <= 1'b1;
      if (blk_done) blk_count   <= blk_count + 16'd1;
    end
  end

  assign fifo_din = '{idx: coef_cnt, data: bus.eng_out};
  assign pop      = bus.m_valid && bus.m_ready;

  dct_coef_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_head),
    .count (fifo_cnt)
  );

  assign bus.m_valid = (fifo_cnt != 3'd0);
  assign bus.m_data  = bus.m_valid ? fifo_head.data : '0;
  assign bus.m_idx   = bus.m_valid ? fifo_head.idx : '0;
  assign bus.m_last  = bus.m_valid && (fifo_head.idx == 2'(NCOEF - 1));
endmodule

// File: tb/tb_dct_block_sequencer.sv
// Directed bench for dct_block_sequencer with a behavioural DA-DCT engine.
module tb_dct_block_sequencer;
  import dct_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_timeout;
  logic [15:0] blk_count;
  int          tests = 0;
  int          fails = 0;

  dct_block_sequencer_if bus();

  dct_block_sequencer #(.TIMEOUT(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_timeout (err_timeout),
    .blk_count   (blk_count)
  );

  always #5 clk = ~clk;

  // engine model: counts cycles out of reset, records the 16 loaded samples,
  // then pulses done every eng_gap cycles with values taken from eng_q
  logic [COEF_W-1:0]   eng_q[$];
  int                  eng_npulse = 4;
  int                  eng_gap = 60;
  int                  eng_ph = 0;
  int                  n_done = 0;
  logic                inj_done = 1'b0;
  logic                inj_load = 1'b0;
  logic [SAMPLE_W-1:0] cap [16];

  always @(negedge clk) begin
    bus.eng_done = 1'b0;
    bus.eng_out  = '0;
    if (inj_done) begin
      bus.eng_done = 1'b1;
      bus.eng_out  = 18'd777;
    end
    if (bus.eng_rst) begin
      eng_ph = 0;
      n_done = 0;
    end else begin
      if (eng_ph < 16) cap[eng_ph] = bus.eng_in;
      if (inj_load && eng_ph == 5) begin
        bus.eng_done = 1'b1;
        bus.eng_out  = 18'd777;
      end
      eng_ph++;
      if (n_done < eng_npulse && eng_ph == 16 + eng_gap * (n_done + 1)) begin
        bus.eng_done = 1'b1;
        bus.eng_out  = (eng_q.size() > 0) ? eng_q.pop_front() : 18'd0;
        n_done++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic [SAMPLE_W-1:0] d);
    int g = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (!bus.s_ready && g < 3000) begin
      step();
      g++;
    end
    if (g >= 3000) chk("send_wait", 0, 1);
    step();
    bus.s_valid = 1'b0;
  endtask

  task automatic send_block(input int base);
    for (int i = 0; i < 16; i++) send(SAMPLE_W'(base + i));
  endtask

  task automatic get_coef(input string nm, input logic [1:0] idx,
                          input logic [COEF_W-1:0] d, input logic last);
    int g = 0;
    bus.m_ready = 1'b1;
    while (!bus.m_valid && g < 2000) begin
      step();
      g++;
    end
    chk({nm, "_valid"}, 32'(bus.m_valid), 1);
    chk({nm, "_data"}, 32'(bus.m_data), 32'(d));
    chk({nm, "_idx_last"}, {29'd0, bus.m_idx, bus.m_last}, {29'd0, idx, last});
    step();
  endtask

  task automatic chk_cap(input string nm, input int base);
    for (int i = 0; i < 16; i++) chk(nm, 32'(cap[i]), 32'(base + i));
  endtask

  typedef struct packed {
    logic [SAMPLE_W-1:0]      base;
    logic [3:0][COEF_W-1:0]   v;
    logic                     inj;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int g;
    int n;
    logic seen;

    vecs[0].base = 15'd1;
    vecs[0].v[0] = 18'd100; vecs[0].v[1] = 18'd200;
    vecs[0].v[2] = 18'd300; vecs[0].v[3] = 18'd400;
    vecs[0].inj  = 1'b0;
    vecs[1].base = 15'd50;
    vecs[1].v[0] = 18'd5;   vecs[1].v[1] = 18'd6;
    vecs[1].v[2] = 18'd7;   vecs[1].v[3] = 18'd8;
    vecs[1].inj  = 1'b1;
    vecs[2].base = 15'h7FEF;
    vecs[2].v[0] = 18'h3FFFF; vecs[2].v[1] = 18'd0;
    vecs[2].v[2] = 18'd1;     vecs[2].v[3] = 18'h20000;
    vecs[2].inj  = 1'b0;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_s_ready", 32'(bus.s_ready), 1);
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_m_fields", {13'd0, bus.m_data, bus.m_idx, bus.m_last}, 0);
    chk("rst_eng_rst", 32'(bus.eng_rst), 1);
    chk("rst_eng_in", 32'(bus.eng_in), 0);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_blk", 32'(blk_count), 0);

    // table: one full block per vector, consumer always ready
    for (int k = 0; k < 3; k++) begin
      bus.m_ready = 1'b1;
      for (int j = 0; j < 4; j++) eng_q.push_back(vecs[k].v[j]);
      if (vecs[k].inj) begin
        inj_done = 1'b1;
        step();
        inj_done = 1'b0;
        step();
        chk("inj_idle_no_push", 32'(bus.m_valid), 0);
        inj_load = 1'b1;
      end
      send_block(int'(vecs[k].base));
      for (int j = 0; j < 4; j++)
        get_coef($sformatf("vec%0d_c%0d", k, j), 2'(j), vecs[k].v[j], j == 3);
      inj_load = 1'b0;
      chk($sformatf("vec%0d_blk", k), 32'(blk_count), 32'(k + 1));
      chk($sformatf("vec%0d_err", k), 32'(err_timeout), 0);
      chk($sformatf("vec%0d_s_ready", k), 32'(bus.s_ready), 1);
      chk_cap($sformatf("vec%0d_eng_in", k), int'(vecs[k].base));
    end

    // backpressure: 48 samples with the consumer stalled
    bus.m_ready = 1'b0;
    for (int j = 0; j < 12; j++) eng_q.push_back(18'(111 + 10 * (j / 4) + (j % 4)));
    for (int i = 0; i < 32; i++) send(SAMPLE_W'(1000 + i));
    chk("bp_s_ready_low", 32'(bus.s_ready), 0);
    for (int i = 32; i < 48; i++) send(SAMPLE_W'(1000 + i));
    chk("bp_both_full", 32'(bus.s_ready), 0);
    chk("bp_head", {bus.m_valid, 11'd0, bus.m_idx, bus.m_data}, {1'b1, 11'd0, 2'd0, 18'd111});
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (!bus.eng_rst) n++;
      step();
    end
    chk("bp_no_restart", 32'(n), 0);
    chk("bp_blk_a", 32'(blk_count), 4);
    for (int j = 0; j < 8; j++)
      get_coef($sformatf("bp_c%0d", j), 2'(j % 4), 18'(111 + 10 * (j / 4) + (j % 4)), (j % 4) == 3);
    chk("bp_blk_b", 32'(blk_count), 5);
    chk("bp_s_ready_back", 32'(bus.s_ready), 1);
    for (int j = 8; j < 12; j++)
      get_coef($sformatf("bp_c%0d", j), 2'(j % 4), 18'(111 + 10 * (j / 4) + (j % 4)), (j % 4) == 3);
    chk("bp_blk_c", 32'(blk_count), 6);
    chk_cap("bp_eng_in_c", 1032);

    // timeout with no done pulses at all
    eng_npulse = 0;
    send_block(5);
    g = 0;
    while (bus.eng_rst && g < 100) begin
      step();
      g++;
    end
    n = 0;
    seen = 1'b0;
    while (!bus.eng_rst && n < 3000) begin
      if (err_timeout) seen = 1'b1;
      if (bus.m_valid) seen = 1'b1;
      step();
      n++;
    end
    chk("to_low_cycles", 32'(n), 16 + 1024);
    chk("to_early_err_or_valid", 32'(seen), 0);
    chk("to_err", 32'(err_timeout), 1);
    chk("to_m_valid", 32'(bus.m_valid), 0);
    chk("to_s_ready", 32'(bus.s_ready), 1);
    chk("to_blk", 32'(blk_count), 6);

    // two pulses then stall
    eng_npulse = 2;
    eng_q.push_back(18'd31);
    eng_q.push_back(18'd32);
    send_block(300);
    get_coef("p2_c0", 2'd0, 18'd31, 1'b0);
    get_coef("p2_c1", 2'd1, 18'd32, 1'b0);
    g = 0;
    while (!bus.eng_rst && g < 2000) begin
      step();
      g++;
    end
    chk("p2_abort_seen", 32'(bus.eng_rst), 1);
    chk("p2_m_valid", 32'(bus.m_valid), 0);
    chk("p2_blk", 32'(blk_count), 6);
    chk("p2_err", 32'(err_timeout), 1);
    eng_npulse = 4;
    for (int j = 0; j < 4; j++) eng_q.push_back(18'(41 + j));
    send_block(400);
    for (int j = 0; j < 4; j++)
      get_coef($sformatf("p2_next_c%0d", j), 2'(j), 18'(41 + j), j == 3);
    chk("p2_next_blk", 32'(blk_count), 7);

    // reset in the middle of LOAD with a partial block also pending
    send_block(500);
    for (int i = 0; i < 5; i++) send(SAMPLE_W'(600 + i));
    g = 0;
    while (!(!bus.eng_rst && eng_ph == 7) && g < 200) begin
      step();
      g++;
    end
    chk("rl_eng_in_7", 32'(bus.eng_in), 507);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rl_eng_rst", 32'(bus.eng_rst), 1);
    chk("rl_s_ready", 32'(bus.s_ready), 1);
    chk("rl_m_valid", 32'(bus.m_valid), 0);
    chk("rl_blk", 32'(blk_count), 0);
    chk("rl_err", 32'(err_timeout), 0);
    step();
    for (int j = 0; j < 4; j++) eng_q.push_back(18'(61 + j));
    send_block(70);
    for (int j = 0; j < 4; j++)
      get_coef($sformatf("rl_c%0d", j), 2'(j), 18'(61 + j), j == 3);
    chk("rl_blk_after", 32'(blk_count), 1);
    chk_cap("rl_eng_in", 70);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
